state_estimate_updater: RTL and testbench

Computes the Kalman state estimate from the gain produced by the covariance stage. Prediction forms x(k|k-1) = A·x(k-1|k-1) + B·u. Update forms x(k|k) = x(k|k-1) + K·(y − C·x(k|k-1)). It sits directly downstream of the covariance generator: its `K` port takes the generator's `t2` gain output, and its start pulses run in lockstep with the generator's `Start_Prediction` / `end_K_G` sequence. A single time-shared fixed-point MAC iterates over matrix elements under a counter-driven FSM.

---
 rtl/kalman_pkg.sv | 51 +++++
 rtl/fixed_point_mac.sv | 50 +++++
 rtl/state_estimate_updater.sv | 213 +++++++++++++++++++++
 tb/tb_state_estimate_updater.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// kalman_pkg: shared FSM encoding, accumulator sizing and fixed-point writeback.
// Build option: SATURATE_EN clamps writeback instead of wrapping.
`default_nettype none

package kalman_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRED_MAC  = 3'd1,
    PRED_DONE = 3'd2,
    INNOV_MAC = 3'd3,
    CORR_MAC  = 3'd4,
    UPD_DONE  = 3'd5
  } est_state_t;

  // Upper bound on any accumulator this package is asked to round.
  localparam int ACC_W_MAX = 128;

  function automatic int acc_width(input int w, input int terms);
    return 2 * w + $clog2(terms) + 1;
  endfunction

  // Returns acc >>> f reduced to a w-bit value in the low bits of the result.
  function automatic logic [ACC_W_MAX-1:0] fx_round(
    input logic signed [ACC_W_MAX-1:0] acc,
    input int                          f,
    input int                          w
  );
    logic signed [ACC_W_MAX-1:0] sh;
`ifdef SATURATE_EN
    logic signed [ACC_W_MAX-1:0] hi;
    logic signed [ACC_W_MAX-1:0] lo;
`endif
    sh = acc >>> f;
`ifdef SATURATE_EN
    hi = ~({ACC_W_MAX{1'b1}} << (w - 1));
    lo = ~hi;
    if (sh > hi) begin
      sh = hi;
    end else if (sh < lo) begin
      sh = lo;
    end
`else
    sh = sh & ~({ACC_W_MAX{1'b1}} << w);
`endif
    return sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_point_mac.sv
// fixed_point_mac: registered multiply-accumulate with preload, add/subtract
// select and a WIDTH-bit writeback of the value being accumulated this cycle.
`default_nettype none

module fixed_point_mac
  import kalman_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int F     = 0,
  parameter int ACC_W = 2 * 16 + 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             en,
  input  logic             clear,
  input  logic             sub,
  input  logic [ACC_W-1:0] preload,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] wb
);

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_base;
  logic [ACC_W-1:0]     acc_next;
  logic [2*WIDTH-1:0]   prod;
  logic [ACC_W-1:0]     prod_ext;
  logic [ACC_W_MAX-1:0] acc_wide;

  // Operands sign-extended to full product width so an unsigned multiply
  // yields the exact two's-complement product.
  assign prod     = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign acc_base = clear ? preload : acc;
  assign acc_next = sub ? (acc_base - prod_ext) : (acc_base + prod_ext);
  assign acc_wide = {{(ACC_W_MAX-ACC_W){acc_next[ACC_W-1]}}, acc_next};
  assign wb       = WIDTH'(fx_round(acc_wide, F, WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clk_en && en) begin
      acc <= acc_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/state_estimate_updater.sv
// state_estimate_updater: Kalman predict/update of x_est on one time-shared MAC.
// Build option: SATURATE_EN selects clamping writeback (see kalman_pkg).
`default_nettype none

module state_estimate_updater
  import kalman_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int intDigits = 16,
  parameter int nos       = 4,
  parameter int noo       = 2,
  parameter int noi       = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clk_en,
  input  logic                               Init,
  input  logic                               Start_Prediction,
  input  logic                               Start_Update,
  input  logic [nos-1:0][nos-1:0][WIDTH-1:0] A,
  input  logic [nos-1:0][noi-1:0][WIDTH-1:0] B,
  input  logic [noo-1:0][nos-1:0][WIDTH-1:0] C,
  input  logic [nos-1:0][noo-1:0][WIDTH-1:0] K,
  input  logic [noi-1:0][WIDTH-1:0]          u,
  input  logic [noo-1:0][WIDTH-1:0]          y,
  input  logic [nos-1:0][WIDTH-1:0]          x0,
  output logic [nos-1:0][WIDTH-1:0]          x_est,
  output logic                               end_Prediction_x,
  output logic                               end_Update_x,
  output logic                               busy
);

  localparam int F     = WIDTH - intDigits;
  localparam int ACC_W = acc_width(WIDTH, nos + noi);
  localparam int CW    = $clog2(nos + noi + noo + 1);

  est_state_t state, next_state;

  logic [CW-1:0]             row, col;
  logic [CW-1:0]             last_row, last_col;
  logic                      col_last, row_last, done_mac;
  logic                      mac_en, sub;
  logic [ACC_W-1:0]          preload;
  logic [WIDTH-1:0]          a_sel, b_sel, wb;
  logic [nos-1:0][WIDTH-1:0] xp;
  logic [noo-1:0][WIDTH-1:0] e;

  function automatic logic [ACC_W-1:0] scale_up(input logic [WIDTH-1:0] v);
    return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v} << F;
  endfunction

  // Operand routing for the current (row, col) of the active MAC phase.
  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    preload  = '0;
    sub      = 1'b0;
    mac_en   = 1'b0;
    last_col = '0;
    last_row = '0;
    case (state)
      PRED_MAC: begin
        mac_en   = 1'b1;
        last_col = CW'(nos + noi - 1);
        last_row = CW'(nos - 1);
        for (int r = 0; r < nos; r++) begin
          for (int c = 0; c < nos; c++) begin
            if (row == CW'(r) && col == CW'(c)) begin
              a_sel = A[r][c];
              b_sel = x_est[c];
            end
          end
          for (int c = 0; c < noi; c++) begin
            if (row == CW'(r) && col == CW'(nos + c)) begin
              a_sel = B[r][c];
              b_sel = u[c];
            end
          end
        end
      end
      INNOV_MAC: begin
        mac_en   = 1'b1;
        sub      = 1'b1;
        last_col = CW'(nos - 1);
        last_row = CW'(noo - 1);
        for (int r = 0; r < noo; r++) begin
          if (row == CW'(r)) preload = scale_up(y[r]);
          for (int c = 0; c < nos; c++) begin
            if (row == CW'(r) && col == CW'(c)) begin
              a_sel = C[r][c];
              b_sel = xp[c];
            end
          end
        end
      end
      CORR_MAC: begin
        mac_en   = 1'b1;
        last_col = CW'(noo - 1);
        last_row = CW'(nos - 1);
        for (int r = 0; r < nos; r++) begin
          if (row == CW'(r)) preload = scale_up(xp[r]);
          for (int c = 0; c < noo; c++) begin
            if (row == CW'(r) && col == CW'(c)) begin
              a_sel = K[r][c];
              b_sel = e[c];
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign col_last = (col == last_col);
  assign row_last = (row == last_row);
  assign done_mac = mac_en && col_last && row_last;

  always_comb begin
    next_state = state;
    case (state)
      IDLE, PRED_DONE, UPD_DONE: begin
        if (state == IDLE && Init)  next_state = IDLE;
        else if (Start_Prediction)  next_state = PRED_MAC;
        else if (Start_Update)      next_state = INNOV_MAC;
        else                        next_state = IDLE;
      end
      PRED_MAC:  if (done_mac) next_state = PRED_DONE;
      INNOV_MAC: if (done_mac) next_state = CORR_MAC;
      CORR_MAC:  if (done_mac) next_state = UPD_DONE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row   <= '0;
      col   <= '0;
      xp    <= '0;
      e     <= '0;
      x_est <= '0;
    end else if (clk_en) begin
      if (mac_en) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        row <= '0;
        col <= '0;
      end

      if (state == IDLE && Init) x_est <= x0;

      // The last prediction row lands in xp and x_est on the same edge so the
      // estimate is valid while end_Prediction_x is high.
      if (state == PRED_MAC && col_last) begin
        for (int k = 0; k < nos; k++) begin
          if (row == CW'(k)) xp[k] <= wb;
        end
        if (row_last) begin
          for (int k = 0; k < nos - 1; k++) x_est[k] <= xp[k];
          x_est[nos-1] <= wb;
        end
      end

      if (state == INNOV_MAC && col_last) begin
        for (int k = 0; k < noo; k++) begin
          if (row == CW'(k)) e[k] <= wb;
        end
      end

      if (state == CORR_MAC && col_last) begin
        for (int k = 0; k < nos; k++) begin
          if (row == CW'(k)) x_est[k] <= wb;
        end
      end
    end
  end

  fixed_point_mac #(
    .WIDTH (WIDTH),
    .F     (F),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .en      (mac_en),
    .clear   (col == '0),
    .sub     (sub),
    .preload (preload),
    .a       (a_sel),
    .b       (b_sel),
    .wb      (wb)
  );

  assign busy             = (state == PRED_MAC) || (state == INNOV_MAC) || (state == CORR_MAC);
  assign end_Prediction_x = (state == PRED_DONE);
  assign end_Update_x     = (state == UPD_DONE);

endmodule

`default_nettype wire

// File: tb/tb_state_estimate_updater.sv
// Testbench for state_estimate_updater in Q8.8 with nos=4, noo=2, noi=1.
`default_nettype none

module tb_state_estimate_updater;

  localparam int W   = 16;
  localparam int NOS = 4;
  localparam int NOO = 2;
  localparam int NOI = 1;

  logic                           clk;
  logic                           reset;
  logic                           clk_en;
  logic                           Init;
  logic                           Start_Prediction;
  logic                           Start_Update;
  logic [NOS-1:0][NOS-1:0][W-1:0] A;
  logic [NOS-1:0][NOI-1:0][W-1:0] B;
  logic [NOO-1:0][NOS-1:0][W-1:0] C;
  logic [NOS-1:0][NOO-1:0][W-1:0] K;
  logic [NOI-1:0][W-1:0]          u;
  logic [NOO-1:0][W-1:0]          y;
  logic [NOS-1:0][W-1:0]          x0;
  logic [NOS-1:0][W-1:0]          x_est;
  logic                           end_Prediction_x;
  logic                           end_Update_x;
  logic                           busy;

  state_estimate_updater #(
    .WIDTH(W), .intDigits(8), .nos(NOS), .noo(NOO), .noi(NOI)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .Init(Init),
    .Start_Prediction(Start_Prediction), .Start_Update(Start_Update),
    .A(A), .B(B), .C(C), .K(K), .u(u), .y(y), .x0(x0),
    .x_est(x_est), .end_Prediction_x(end_Prediction_x),
    .end_Update_x(end_Update_x), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int OP_INIT = 0;
  localparam int OP_PRED = 1;
  localparam int OP_UPD  = 2;

  typedef struct {
    int          op;
    logic [63:0] xinit;
    logic [15:0] ad;
    logic [15:0] bv;
    logic [15:0] uv;
    logic [63:0] exp_x;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_pred_mats(input logic [15:0] ad, input logic [15:0] bv, input logic [15:0] uv);
    for (int r = 0; r < NOS; r++) begin
      for (int c = 0; c < NOS; c++) A[r][c] = (r == c) ? ad : 16'h0000;
      B[r][0] = bv;
    end
    u[0] = uv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses a start and counts edges (sampling edge = 1) until the end pulse.
  task automatic do_start(input bit pred, output int lat);
    if (pred) Start_Prediction = 1'b1;
    else      Start_Update     = 1'b1;
    tick();
    Start_Prediction = 1'b0;
    Start_Update     = 1'b0;
    lat = 1;
    while (!(pred ? end_Prediction_x : end_Update_x) && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_init(input logic [63:0] xv);
    x0   = xv;
    Init = 1'b1;
    tick();
    Init = 1'b0;
  endtask

  initial begin
    int lat;
    int pc, uc, en_edges;

    vecs[0]  = '{OP_INIT, 64'h0400_0300_0200_0100, 16'h0, 16'h0, 16'h0, 64'h0400_0300_0200_0100, 1};
    vecs[1]  = '{OP_PRED, 64'h0, 16'h0100, 16'h0080, 16'h0200, 64'h0500_0400_0300_0200, 21};
    vecs[2]  = '{OP_UPD,  64'h0, 16'h0,    16'h0,    16'h0,    64'h0500_0400_0300_0300, 17};
    vecs[3]  = '{OP_PRED, 64'h0, 16'h0100, 16'h0080, 16'hFE00, 64'h0400_0300_0200_0200, 21};
    vecs[4]  = '{OP_UPD,  64'h0, 16'h0,    16'h0,    16'h0,    64'h0400_0300_0280_0300, 17};
    vecs[5]  = '{OP_PRED, 64'h0, 16'h0080, 16'h0040, 16'h0100, 64'h0240_01C0_0180_01C0, 21};
    vecs[6]  = '{OP_INIT, 64'h7F00_7F00_7F00_7F00, 16'h0, 16'h0, 16'h0, 64'h7F00_7F00_7F00_7F00, 1};
`ifdef SATURATE_EN
    vecs[7]  = '{OP_PRED, 64'h0, 16'h7F00, 16'h0, 16'h0, 64'h7FFF_7FFF_7FFF_7FFF, 21};
`else
    vecs[7]  = '{OP_PRED, 64'h0, 16'h7F00, 16'h0, 16'h0, 64'h0100_0100_0100_0100, 21};
`endif
    vecs[8]  = '{OP_INIT, 64'h8100_7F00_8100_7F00, 16'h0, 16'h0, 16'h0, 64'h8100_7F00_8100_7F00, 1};
`ifdef SATURATE_EN
    vecs[9]  = '{OP_PRED, 64'h0, 16'h7F00, 16'h0, 16'h0, 64'h8000_7FFF_8000_7FFF, 21};
`else
    vecs[9]  = '{OP_PRED, 64'h0, 16'h7F00, 16'h0, 16'h0, 64'hFF00_0100_FF00_0100, 21};
`endif
    vecs[10] = '{OP_INIT, 64'h0003_FFFF_0001_FFFF, 16'h0, 16'h0, 16'h0, 64'h0003_FFFF_0001_FFFF, 1};
    vecs[11] = '{OP_PRED, 64'h0, 16'h0080, 16'h0, 16'h0, 64'h0001_FFFF_0000_FFFF, 21};
    vecs[12] = '{OP_UPD,  64'h0, 16'h0,    16'h0,    16'h0,    64'h0001_FFFF_0180_01FF, 17};

    reset = 1'b0; clk_en = 1'b1; Init = 1'b0;
    Start_Prediction = 1'b0; Start_Update = 1'b0;
    A = '0; B = '0; C = '0; K = '0; u = '0; y = '0; x0 = '0;
    C[0][0] = 16'h0100; C[1][1] = 16'h0100;
    K[0][0] = 16'h0080; K[1][1] = 16'h0080;
    y[0] = 16'h0400; y[1] = 16'h0300;

    repeat (3) tick();
    check("reset_x_est", x_est, 64'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_ends", {end_Prediction_x, end_Update_x}, 2'b00);
    reset = 1'b1;
    tick();
    check("post_reset_x_est", x_est, 64'h0);

    for (int i = 0; i < 13; i++) begin
      case (vecs[i].op)
        OP_INIT: begin
          do_init(vecs[i].xinit);
          check($sformatf("v%0d_init_x", i), x_est, vecs[i].exp_x);
        end
        default: begin
          set_pred_mats(vecs[i].ad, vecs[i].bv, vecs[i].uv);
          do_start(vecs[i].op == OP_PRED, lat);
          check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
          check($sformatf("v%0d_x_est", i), x_est, vecs[i].exp_x);
          tick();
          check($sformatf("v%0d_pulse_width", i), {end_Prediction_x, end_Update_x, busy}, 3'b000);
        end
      endcase
    end

    // Both starts together: prediction wins; a Start_Update while busy is dropped.
    do_init(64'h0400_0300_0200_0100);
    set_pred_mats(16'h0100, 16'h0080, 16'h0200);
    Start_Prediction = 1'b1;
    Start_Update     = 1'b1;
    tick();
    Start_Prediction = 1'b0;
    Start_Update     = 1'b0;
    check("both_starts_busy", busy, 1'b1);
    pc = 0; uc = 0;
    for (int t = 0; t < 40; t++) begin
      Start_Update = (t == 5);
      tick();
      if (end_Prediction_x) pc++;
      if (end_Update_x) uc++;
    end
    Start_Update = 1'b0;
    check("both_starts_pred_pulses", pc, 1);
    check("both_starts_upd_pulses", uc, 0);
    check("both_starts_x_est", x_est, 64'h0500_0400_0300_0200);

    // Reset during the 10th cycle of a prediction aborts it.
    Start_Prediction = 1'b1;
    tick();
    Start_Prediction = 1'b0;
    repeat (9) tick();
    reset = 1'b0;
    #2;
    check("abort_x_est", x_est, 64'h0);
    check("abort_busy", busy, 1'b0);
    tick();
    reset = 1'b1;
    pc = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (end_Prediction_x || end_Update_x) pc++;
    end
    check("abort_no_pulse", pc, 0);
    do_start(1'b1, lat);
    check("after_abort_latency", lat, 21);
    check("after_abort_x_est", x_est, 64'h0100_0100_0100_0100);
    tick();

    // Clock enable alternating every cycle.
    do_init(64'h0400_0300_0200_0100);
    Start_Prediction = 1'b1;
    tick();
    Start_Prediction = 1'b0;
    en_edges = 1;
    for (int g = 0; g < 200 && !end_Prediction_x; g++) begin
      clk_en = ~clk_en;
      tick();
      if (clk_en) en_edges++;
    end
    check("clken_latency", en_edges, 21);
    check("clken_x_est", x_est, 64'h0500_0400_0300_0200);
    clk_en = 1'b0;
    tick();
    check("clken_pulse_held", end_Prediction_x, 1'b1);
    clk_en = 1'b1;
    tick();
    check("clken_pulse_cleared", end_Prediction_x, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
